io_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter. It is a responder on the core's IO bus, which occupies
//  the 4th address quadrant: the CPU writes bytes over bus_addr/bus_wdata/bus_we, and the

---
 rtl/io_uart_tx_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 53 +++++
 rtl/io_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_io_uart_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_tx_pkg.sv
// Register map, status layout and FSM encoding shared by the UART transmitter files.
// Pure declarations: no logic, no latency, no flow control.
package io_uart_tx_pkg;

  localparam logic [31:0] UART_BASE_ADDR  = 32'hC000_0000;

  localparam logic [3:0]  UART_TXDATA_OFS = 4'h0;
  localparam logic [3:0]  UART_STATUS_OFS = 4'h4;
  localparam logic [3:0]  UART_BAUD_OFS   = 4'h8;

  localparam logic [1:0]  REG_TXDATA = UART_TXDATA_OFS[3:2];
  localparam logic [1:0]  REG_STATUS = UART_STATUS_OFS[3:2];
  localparam logic [1:0]  REG_BAUD   = UART_BAUD_OFS[3:2];

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef struct packed {
    logic [3:0] count;
    logic       overflow;
    logic       empty;
    logic       full;
    logic       busy;
  } status_t;

  function automatic logic [3:0] sat_count(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, show-ahead read; push/pop take effect at the clock edge.
// Pop when empty is ignored; push when full is ignored unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_d    = do_push ? wr_q + PtrOne : wr_q;
  assign rd_d    = do_pop  ? rd_q + PtrOne : rd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, STATUS, BAUD_DIV; reads return one cycle after the address.
// Never stalls the bus: a TXDATA write into a full FIFO is dropped and raises sticky overflow.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter logic [31:0] BaseAddr   = UART_BASE_ADDR,
  parameter int          FifoDepth  = 8,
  parameter logic [15:0] DefaultDiv = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        uart_tx
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  logic            sel;
  logic [1:0]      idx;
  logic            wr_txdata, wr_status, wr_baud;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  status_t         status;

  logic [1:0]  state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tick;
  logic        unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

  assign sel       = (bus_addr[31:4] == BaseAddr[31:4]);
  assign idx       = bus_addr[3:2];
  assign wr_txdata = sel && bus_we && (idx == REG_TXDATA);
  assign wr_status = sel && bus_we && (idx == REG_STATUS);
  assign wr_baud   = sel && bus_we && (idx == REG_BAUD);

  // The FSM only pops while idle; a same-cycle pop makes room for a push into a full FIFO.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);
  assign drop      = wr_txdata && fifo_full && !fifo_pop;

  sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && bus_wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (drop)                                 ovf_d = 1'b1;
  end

  always_comb begin
    baud_d = baud_q;
    if (wr_baud) baud_d = (bus_wdata[15:0] < MIN_DIV) ? MIN_DIV : bus_wdata[15:0];
  end

  always_comb begin
    status          = '0;
    status.busy     = (state_q != IDLE);
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.overflow = ovf_q;
    status.count    = sat_count(32'(fifo_count));
  end

  always_comb begin
    rdata_d = 32'h0;
    if (sel) begin
      case (idx)
        REG_STATUS: rdata_d = {24'h0, status};
        REG_BAUD:   rdata_d = {16'h0, baud_q};
        default:    rdata_d = 32'h0;
      endcase
    end
  end

  assign tick = (cnt_q == div_q - 16'd1);

  // tx_q follows the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    div_d     = div_q;
    cnt_d     = tick ? 16'd0 : cnt_q + 16'd1;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (!fifo_empty) begin
          state_d   = START;
          shreg_d   = fifo_rdata;
          div_d     = baud_q;
          bit_idx_d = 3'd0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: begin
        tx_d = 1'b1;
        if (tick) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h0;
      bit_idx_q <= 3'd0;
      cnt_q     <= 16'd0;
      div_q     <= DefaultDiv;
      baud_q    <= DefaultDiv;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register access, frame timing, overflow, reset and decode.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_uart_tx;

  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_BD = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        clk;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  io_uart_tx #(
    .BaseAddr   (BASE),
    .FifoDepth  (8),
    .DefaultDiv (16'd868)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .uart_tx   (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
  endtask

  task automatic expect_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_addr = a;
    bus_we   = 1'b0;
    @(negedge clk);
    check(tag, bus_rdata, exp);
    bus_addr = 32'h0;
  endtask

  // Samples one whole frame; first sample is the cycle the start bit appears.
  task automatic tx_frame(input logic [7:0] b, input int div, input bit chk_busy, input string tag);
    logic [9:0] exp;
    logic [9:0] obs;
    logic       bad;
    int         not_busy;
    exp      = {1'b1, b, 1'b0};
    obs      = '0;
    bad      = 1'b0;
    not_busy = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < div; j++) begin
        @(negedge clk);
        if (j == 0) obs[i] = uart_tx;
        else if (uart_tx !== obs[i]) bad = 1'b1;
        if (chk_busy && bus_rdata[0] !== 1'b1) not_busy++;
      end
    end
    check(tag, {21'h0, bad, obs}, {21'h0, 1'b0, exp});
    if (chk_busy) check({tag, "_busy"}, not_busy, 0);
  endtask

  task automatic quiet(input int n, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  function automatic logic [7:0] burst_byte(input int k);
    case (k)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h55;
      3: return 8'hAA;
      4: return 8'h01;
      5: return 8'h80;
      6: return 8'h3C;
      7: return 8'hC3;
      default: return 8'h96;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_we    = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_rdata", bus_rdata, 32'h0);
    rst = 1'b1;
    expect_read("rst_status", A_ST, 32'h4);
    expect_read("rst_baud", A_BD, 32'd868);

    // Single byte at div 4
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'hA5);
    bus_addr = A_ST;
    @(negedge clk);
    check("t2_latency_idle", {31'h0, uart_tx}, 32'h1);
    tx_frame(8'hA5, 4, 1'b1, "t2_frame_a5");
    expect_read("t2_status_end", A_ST, 32'h4);

    // Burst of nine, tenth dropped, overflow W1C
    bus_write(A_BD, 32'd2);
    fork
      begin
        repeat (2) @(negedge clk);
        check("t3_latency_idle", {31'h0, uart_tx}, 32'h1);
        for (int k = 0; k < 9; k++) begin
          if (k > 0) begin
            @(negedge clk);
            check("t3_gap", {31'h0, uart_tx}, 32'h1);
          end
          tx_frame(burst_byte(k), 2, 1'b0, "t3_frame");
        end
      end
      begin
        for (int k = 0; k < 9; k++) bus_write(A_TX, {24'h0, burst_byte(k)});
        expect_read("t3_full", A_ST, 32'h83);
        bus_write(A_TX, 32'hEE);
        expect_read("t3_overflow", A_ST, 32'h8B);
        bus_write(A_ST, 32'h7);
        expect_read("t3_ovf_hold", A_ST, 32'h8B);
        bus_write(A_ST, 32'h8);
        expect_read("t3_ovf_clear", A_ST, 32'h83);
      end
    join
    quiet(60, "t3_no_dropped_byte");
    expect_read("t3_status_end", A_ST, 32'h4);

    // Divider change mid-frame
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h3A);
    bus_write(A_TX, 32'hC5);
    fork
      begin
        tx_frame(8'h3A, 4, 1'b0, "t4_frame_div4");
        @(negedge clk);
        check("t4_gap", {31'h0, uart_tx}, 32'h1);
        tx_frame(8'hC5, 8, 1'b0, "t4_frame_div8");
      end
      begin
        repeat (8) @(negedge clk);
        bus_write(A_BD, 32'd8);
      end
    join
    expect_read("t4_baud8", A_BD, 32'd8);
    bus_write(A_BD, 32'd1);
    expect_read("t4_baud1_clamp", A_BD, 32'd2);
    bus_write(A_BD, 32'd0);
    expect_read("t4_baud0_clamp", A_BD, 32'd2);

    // Reset mid-frame
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'hF0);
    repeat (6) @(negedge clk);
    check("t5_pre_rst_low", {31'h0, uart_tx}, 32'h0);
    bus_addr = A_ST;
    rst      = 1'b0;
    @(negedge clk);
    check("t5_rst_tx", {31'h0, uart_tx}, 32'h1);
    check("t5_rst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    rst      = 1'b1;
    bus_addr = 32'h0;
    expect_read("t5_status", A_ST, 32'h4);
    expect_read("t5_baud", A_BD, 32'd868);
    quiet(40, "t5_no_residual");

    // Decode and read timing
    bus_write(BASE + 32'h18, 32'd5);
    expect_read("t6_alias_baud", A_BD, 32'd868);
    bus_write(BASE + 32'h10, 32'h55);
    expect_read("t6_alias_txdata", A_ST, 32'h4);
    expect_read("t6_read_10", BASE + 32'h10, 32'h0);
    expect_read("t6_read_14", BASE + 32'h14, 32'h0);
    expect_read("t6_other_quadrant", 32'h4000_0008, 32'h0);
    bus_write(A_RS, 32'hFFFF_FFFF);
    expect_read("t6_reserved", A_RS, 32'h0);
    expect_read("t6_status_after_rsvd", A_ST, 32'h4);
    @(negedge clk);
    check("t6_idle_rdata", bus_rdata, 32'h0);
    bus_addr = A_BD;
    #1;
    check("t6_not_comb", bus_rdata, 32'h0);
    @(negedge clk);
    check("t6_one_cycle", bus_rdata, 32'd868);
    bus_addr = 32'h0;
    @(negedge clk);
    check("t6_back_to_zero", bus_rdata, 32'h0);
    quiet(5, "t6_line_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
